// File: rtl/ahb_lite_slave_mem.sv
// Single-port AHB-Lite memory slave with byte lanes, programmable wait states and two-cycle ERROR.
// Zero-wait reads return data the cycle after the address phase; HREADYOUT drops for wait_states cycles per OKAY transfer.
module ahb_lite_slave_mem #(
  parameter int addr_width  = 32,
  parameter int data_width  = 32,
  parameter int mem_depth   = 256,
  parameter int wait_states = 0
) (
  input  logic                  clk,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [addr_width-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBRUST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic [data_width-1:0] HWDATA,
  output logic [data_width-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);
  localparam int IW = $clog2(mem_depth);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  write_q, write_d;
  logic [3:0]            mask_q, mask_d;
  logic [data_width-1:0] rdata_q, rdata_d;
  logic [data_width-1:0] mem [mem_depth];

  logic                  can_accept, accept, err, misalign, commit, load_rd;
  logic [addr_width-3:0] word_addr;
  logic [3:0]            lane_mask;
  logic [data_width-1:0] wr_merge, rd_word;
  logic                  unused_inputs;

  assign unused_inputs = ^{HBRUST, HPROT, HMASTLOCK};

  assign word_addr  = HADDR[addr_width-1:2];
  assign can_accept = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign accept     = can_accept && HSEL && HREADY && HTRANS[1];

  always_comb begin
    lane_mask = 4'b1111;
    misalign  = 1'b0;
    case (HSIZE)
      3'b000:  lane_mask = 4'b0001 << HADDR[1:0];
      3'b001: begin
        lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
        misalign  = HADDR[0];
      end
      3'b010:  misalign = |HADDR[1:0];
      default: ;
    endcase
  end

  assign err = (word_addr >= (addr_width-2)'(mem_depth)) || (HSIZE > 3'b010) || misalign;

  // Byte-enabled merge of the write in its data phase; also the read bypass source.
  always_comb begin
    wr_merge = mem[idx_q];
    for (int b = 0; b < 4; b++) begin
      if (mask_q[b]) wr_merge[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  assign commit = (state_q == S_DATA) && write_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    mask_d  = mask_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_DATA;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = word_addr[IW-1:0];
          write_d = HWRITE;
          mask_d  = lane_mask;
          if (err) begin
            state_d = S_ERR1;
          end else if (wait_states > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(wait_states);
          end else begin
            state_d = S_DATA;
          end
        end
      end
    endcase
  end

  // idx_d names the word entering DATA on both the direct-accept and end-of-wait paths.
  assign load_rd = (state_d == S_DATA) && !write_d;
  assign rd_word = (commit && (idx_q == idx_d)) ? wr_merge : mem[idx_d];

  always_comb begin
    rdata_d = rdata_q;
    if (load_rd) rdata_d = rd_word;
  end

  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      mask_q  <= 4'b0000;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) mem[idx_q] <= wr_merge;
  end

  assign HRDATA    = rdata_q;
  assign HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Directed bench for ahb_lite_slave_mem: zero-wait, wait-state (2 and 3) instances on a shared bus.
module tb_ahb_lite_slave_mem;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  logic        clk;
  logic        hresetn;
  logic        hsel0, hsel2, hsel3;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic [31:0] hrdata0, hrdata2, hrdata3;
  logic        ready0, ready2, ready3;
  logic        resp0, resp2, resp3;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_lite_slave_mem #(.wait_states(0)) u0 (
    .clk(clk), .HRESETn(hresetn), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBRUST(hburst), .HPROT(4'h3), .HTRANS(htrans), .HMASTLOCK(1'b0),
    .HREADY(ready0), .HWDATA(hwdata), .HRDATA(hrdata0), .HREADYOUT(ready0), .HRESP(resp0)
  );

  ahb_lite_slave_mem #(.wait_states(2)) u2 (
    .clk(clk), .HRESETn(hresetn), .HSEL(hsel2), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBRUST(hburst), .HPROT(4'h3), .HTRANS(htrans), .HMASTLOCK(1'b0),
    .HREADY(ready2), .HWDATA(hwdata), .HRDATA(hrdata2), .HREADYOUT(ready2), .HRESP(resp2)
  );

  ahb_lite_slave_mem #(.wait_states(3)) u3 (
    .clk(clk), .HRESETn(hresetn), .HSEL(hsel3), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBRUST(hburst), .HPROT(4'h3), .HTRANS(htrans), .HMASTLOCK(1'b0),
    .HREADY(ready3), .HWDATA(hwdata), .HRDATA(hrdata3), .HREADYOUT(ready3), .HRESP(resp3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic addr_ph(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                         input logic [31:0] a);
    htrans = tr;
    hwrite = wr;
    hsize  = sz;
    haddr  = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] bv [4];
    bv[0] = 32'h0000_0011; bv[1] = 32'h0000_0022; bv[2] = 32'h0000_0033; bv[3] = 32'h0000_0044;

    hresetn = 1'b1;
    hsel0 = 1'b0; hsel2 = 1'b0; hsel3 = 1'b0;
    hburst = 3'b000; hwdata = 32'h0;
    addr_ph(IDLE, 1'b0, 3'b010, 32'h0);
    #3 hresetn = 1'b0;
    step(); step();
    chk1("rst_readyout", ready0, 1'b1);
    chk1("rst_resp", resp0, 1'b0);
    chk32("rst_rdata", hrdata0, 32'h0);
    hresetn = 1'b1;
    step();

    // Zero-wait single write then read; the read is accepted as the write commits.
    hsel0 = 1'b1;
    addr_ph(NONSEQ, 1'b1, 3'b010, 32'h10); step();
    hwdata = 32'hDEAD_BEEF; addr_ph(NONSEQ, 1'b0, 3'b010, 32'h10);
    chk1("single_wr_ready", ready0, 1'b1);
    chk1("single_wr_resp", resp0, 1'b0);
    step();
    addr_ph(IDLE, 1'b0, 3'b010, 32'h0);
    chk32("single_rd_data", hrdata0, 32'hDEAD_BEEF);
    chk1("single_rd_resp", resp0, 1'b0);
    step();

    // BUSY yields no data phase and leaves HRDATA alone.
    addr_ph(BUSY, 1'b0, 3'b010, 32'h40); step();
    addr_ph(IDLE, 1'b0, 3'b010, 32'h0);
    chk1("busy_ready", ready0, 1'b1);
    chk1("busy_resp", resp0, 1'b0);
    chk32("busy_rdata_held", hrdata0, 32'hDEAD_BEEF);
    step();

    // INCR4 write then INCR4 read, one transfer per cycle.
    hburst = 3'b011;
    addr_ph(NONSEQ, 1'b1, 3'b010, 32'h20); step();
    for (int i = 0; i < 4; i++) begin
      hwdata = bv[i];
      if (i < 3) addr_ph(SEQ, 1'b1, 3'b010, 32'h24 + 32'(4 * i));
      else       addr_ph(NONSEQ, 1'b0, 3'b010, 32'h20);
      chk1("burst_wr_ready", ready0, 1'b1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      if (i < 3) addr_ph(SEQ, 1'b0, 3'b010, 32'h24 + 32'(4 * i));
      else       addr_ph(IDLE, 1'b0, 3'b010, 32'h0);
      chk1("burst_rd_ready", ready0, 1'b1);
      chk32("burst_rd_data", hrdata0, bv[i]);
      step();
    end
    hburst = 3'b000;

    // Byte and halfword lanes over a preloaded all-ones word.
    addr_ph(NONSEQ, 1'b1, 3'b010, 32'h40); step();
    hwdata = 32'hFFFF_FFFF; addr_ph(NONSEQ, 1'b1, 3'b000, 32'h41); step();
    hwdata = 32'h5555_AB55; addr_ph(NONSEQ, 1'b0, 3'b010, 32'h40); step();
    chk32("byte_lane_bypass", hrdata0, 32'hFFFF_ABFF);
    addr_ph(NONSEQ, 1'b1, 3'b001, 32'h42); step();
    hwdata = 32'h1234_6666; addr_ph(IDLE, 1'b0, 3'b010, 32'h0); step();
    addr_ph(NONSEQ, 1'b0, 3'b010, 32'h40); step();
    addr_ph(IDLE, 1'b0, 3'b010, 32'h0);
    chk32("half_lane_read", hrdata0, 32'h1234_ABFF);
    step();

    // Out-of-range read: two-cycle ERROR, HRDATA not reloaded.
    addr_ph(NONSEQ, 1'b0, 3'b010, 32'h400); step();
    addr_ph(IDLE, 1'b0, 3'b010, 32'h0);
    chk1("range_err1_ready", ready0, 1'b0);
    chk1("range_err1_resp", resp0, 1'b1);
    step();
    chk1("range_err2_ready", ready0, 1'b1);
    chk1("range_err2_resp", resp0, 1'b1);
    step();
    chk1("range_after_resp", resp0, 1'b0);
    chk32("range_rdata_held", hrdata0, 32'h1234_ABFF);

    // Misaligned halfword write to 0x01 must not touch word 0.
    addr_ph(NONSEQ, 1'b1, 3'b010, 32'h0); step();
    hwdata = 32'hCAFE_F00D; addr_ph(NONSEQ, 1'b1, 3'b001, 32'h01); step();
    hwdata = 32'h0000_0000; addr_ph(IDLE, 1'b0, 3'b010, 32'h0);
    chk1("misalign_err1_ready", ready0, 1'b0);
    chk1("misalign_err1_resp", resp0, 1'b1);
    step();
    chk1("misalign_err2_ready", ready0, 1'b1);
    chk1("misalign_err2_resp", resp0, 1'b1);
    step();
    addr_ph(NONSEQ, 1'b0, 3'b010, 32'h0); step();
    addr_ph(IDLE, 1'b0, 3'b010, 32'h0);
    chk32("misalign_mem_kept", hrdata0, 32'hCAFE_F00D);
    step();

    // Oversize transfer is an error too.
    addr_ph(NONSEQ, 1'b0, 3'b011, 32'h0); step();
    addr_ph(IDLE, 1'b0, 3'b010, 32'h0);
    chk1("oversize_resp", resp0, 1'b1);
    step(); step();
    hsel0 = 1'b0;

    // Two wait states: write, then a held read accepted only at the write's DATA cycle.
    hsel2 = 1'b1;
    addr_ph(NONSEQ, 1'b1, 3'b010, 32'h80); step();
    hwdata = 32'h0BAD_CAFE; addr_ph(NONSEQ, 1'b0, 3'b010, 32'h80);
    chk1("ws2_wr_wait1", ready2, 1'b0); step();
    chk1("ws2_wr_wait2", ready2, 1'b0); step();
    chk1("ws2_wr_data", ready2, 1'b1); step();
    addr_ph(IDLE, 1'b0, 3'b010, 32'h0);
    chk1("ws2_rd_wait1", ready2, 1'b0); step();
    chk1("ws2_rd_wait2", ready2, 1'b0);
    chk1("ws2_rd_resp", resp2, 1'b0); step();
    chk1("ws2_rd_ready", ready2, 1'b1);
    chk32("ws2_rd_data", hrdata2, 32'h0BAD_CAFE);
    step();
    hsel2 = 1'b0;

    // Three wait states: establish a value, then reset in the middle of a second write.
    hsel3 = 1'b1;
    addr_ph(NONSEQ, 1'b1, 3'b010, 32'h90); step();
    hwdata = 32'h600D_D00D; addr_ph(NONSEQ, 1'b0, 3'b010, 32'h90);
    for (int i = 0; i < 3; i++) begin
      chk1("ws3_wr_wait", ready3, 1'b0); step();
    end
    chk1("ws3_wr_data", ready3, 1'b1); step();
    addr_ph(NONSEQ, 1'b1, 3'b010, 32'h90);
    for (int i = 0; i < 3; i++) begin
      chk1("ws3_rd_wait", ready3, 1'b0); step();
    end
    chk1("ws3_rd_ready", ready3, 1'b1);
    chk32("ws3_rd_data", hrdata3, 32'h600D_D00D);
    step();
    hwdata = 32'hBAD0_BAD0; addr_ph(IDLE, 1'b0, 3'b010, 32'h0);
    chk1("ws3_mid_wait1", ready3, 1'b0); step();
    chk1("ws3_mid_wait2", ready3, 1'b0);
    hresetn = 1'b0;
    #1;
    chk1("ws3_rst_ready", ready3, 1'b1);
    chk1("ws3_rst_resp", resp3, 1'b0);
    chk32("ws3_rst_rdata", hrdata3, 32'h0);
    step(); step();
    hresetn = 1'b1;
    step();
    chk1("ws3_post_rst_ready", ready3, 1'b1);
    addr_ph(NONSEQ, 1'b0, 3'b010, 32'h90); step();
    addr_ph(IDLE, 1'b0, 3'b010, 32'h0);
    step(); step(); step();
    chk1("ws3_reread_ready", ready3, 1'b1);
    chk32("ws3_write_dropped", hrdata3, 32'h600D_D00D);
    step();
    hsel3 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
